// File: rtl/draw_text_box_if.sv
// vga_if: VGA timing plus 12-bit rgb bundle (38 bits) passed between pipeline stages.
interface vga_if;
  logic [10:0] vcount;
  logic        vsync;
  logic        vblnk;
  logic [10:0] hcount;
  logic        hsync;
  logic        hblnk;
  logic [11:0] rgb;

  modport in  (input  vcount, vsync, vblnk, hcount, hsync, hblnk, rgb);
  modport out (output vcount, vsync, vblnk, hcount, hsync, hblnk, rgb);
endinterface

// File: rtl/draw_text_box.sv
// draw_text_box: text-window overlay with its own character buffer, external font ROM,
// blinking cursor and a clear-screen FSM. Define TEXT_SCALE2_EN to draw glyphs at 2x.
module draw_text_box #(
  parameter int          X0           = 48,
  parameter int          Y0           = 64,
  parameter int          COLS         = 16,
  parameter int          ROWS         = 16,
  parameter logic [11:0] FG           = 12'hfff,
  parameter logic [11:0] BG           = 12'h45c,
  parameter int          TRANSPARENT  = 0,
  parameter int          BLINK_FRAMES = 30,
  localparam int         N            = COLS * ROWS,
  localparam int         AW           = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          rst,
  vga_if.in             vga_in,
  vga_if.out            vga_out,
  output logic [7:0]    char_code,
  output logic [3:0]    char_line,
  input  logic [7:0]    char_pixels,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [7:0]    wr_data,
  output logic          wr_ready,
  input  logic          clr,
  output logic          busy,
  input  logic          cursor_en,
  input  logic [AW-1:0] cursor_addr
);

`ifdef TEXT_SCALE2_EN
  localparam int SC = 1;
`else
  localparam int SC = 0;
`endif

  localparam int          BW   = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [11:0] X_LO = 12'(X0);
  localparam logic [11:0] X_HI = 12'(X0 + COLS * (8 << SC));
  localparam logic [11:0] Y_LO = 12'(Y0);
  localparam logic [11:0] Y_HI = 12'(Y0 + ROWS * (16 << SC));

  typedef struct packed {
    logic [10:0] vcount;
    logic        vsync;
    logic        vblnk;
    logic [10:0] hcount;
    logic        hsync;
    logic        hblnk;
    logic [11:0] rgb;
  } vgaSig_t;

  typedef enum logic {IDLE, CLEAR} state_t;

  logic [7:0]    textMem [N];

  state_t        state_q;
  logic [AW-1:0] clrAddr_q;
  logic          busy_q;

  logic          vsyncPrev_q;
  logic [BW-1:0] blinkCnt_q;
  logic          blinkPhase_q;

  logic [10:0]   hRel, vRel, colIdx, rowIdx;
  logic [AW-1:0] rdAddr_d;
  logic [2:0]    pixCol_d;
  logic [3:0]    line_d;
  logic          inWin_d, cursor_d;

  logic [7:0]    charCode_q;
  logic [3:0]    charLine_q;
  logic          inWin1_q, inWin2_q, cursor1_q, cursor2_q;
  logic [2:0]    pixCol1_q, pixCol2_q;
  vgaSig_t       vga1_q, vga2_q, vga3_q, out_d;

  logic          glyphBit, showFg;
  logic          userWrite, memWe;
  logic [AW-1:0] memAddr;
  logic [7:0]    memData;

  // Cell index and glyph coordinates of the incoming pixel; only meaningful inside the window.
  always_comb begin
    hRel     = vga_in.hcount - 11'(X0);
    vRel     = vga_in.vcount - 11'(Y0);
    colIdx   = hRel >> (3 + SC);
    rowIdx   = vRel >> (4 + SC);
    rdAddr_d = AW'(rowIdx) * AW'(COLS) + AW'(colIdx);
    pixCol_d = 3'(hRel >> SC);
    line_d   = 4'(vRel >> SC);
    inWin_d  = ({1'b0, vga_in.hcount} >= X_LO) && ({1'b0, vga_in.hcount} < X_HI) &&
               ({1'b0, vga_in.vcount} >= Y_LO) && ({1'b0, vga_in.vcount} < Y_HI);
    cursor_d = cursor_en && blinkPhase_q && (rdAddr_d == cursor_addr);
  end

  // The clear FSM owns the single RAM write port while busy, so user writes are simply gated off.
  always_comb begin
    userWrite = wr_en && !busy_q && ({1'b0, wr_addr} < (AW + 1)'(N));
    memWe     = (state_q == CLEAR) || userWrite;
    memAddr   = (state_q == CLEAR) ? clrAddr_q : wr_addr;
    memData   = (state_q == CLEAR) ? 8'h20 : wr_data;
  end

  always_ff @(posedge clk) begin
    if (memWe) textMem[memAddr] <= memData;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= CLEAR;
      clrAddr_q <= '0;
      busy_q    <= 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (clr) begin
            state_q   <= CLEAR;
            clrAddr_q <= '0;
            busy_q    <= 1'b1;
          end
        end
        CLEAR: begin
          if (clrAddr_q == AW'(N - 1)) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else begin
            clrAddr_q <= clrAddr_q + AW'(1);
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vsyncPrev_q  <= 1'b0;
      blinkCnt_q   <= '0;
      blinkPhase_q <= 1'b0;
    end else begin
      vsyncPrev_q <= vga_in.vsync;
      if (vga_in.vsync && !vsyncPrev_q) begin
        if (blinkCnt_q == BW'(BLINK_FRAMES - 1)) begin
          blinkCnt_q   <= '0;
          blinkPhase_q <= !blinkPhase_q;
        end else begin
          blinkCnt_q <= blinkCnt_q + BW'(1);
        end
      end
    end
  end

  // Stage 1 holds the RAM read and glyph coordinates; stage 2 lines up with the ROM's registered output.
  always_ff @(posedge clk) begin
    if (rst) begin
      charCode_q <= '0;
      charLine_q <= '0;
      inWin1_q   <= 1'b0;
      cursor1_q  <= 1'b0;
      pixCol1_q  <= '0;
      vga1_q     <= '0;
      inWin2_q   <= 1'b0;
      cursor2_q  <= 1'b0;
      pixCol2_q  <= '0;
      vga2_q     <= '0;
      vga3_q     <= '0;
    end else begin
      charCode_q <= textMem[rdAddr_d];
      charLine_q <= line_d;
      inWin1_q   <= inWin_d;
      cursor1_q  <= cursor_d;
      pixCol1_q  <= pixCol_d;
      vga1_q     <= {vga_in.vcount, vga_in.vsync, vga_in.vblnk,
                     vga_in.hcount, vga_in.hsync, vga_in.hblnk, vga_in.rgb};
      inWin2_q   <= inWin1_q;
      cursor2_q  <= cursor1_q;
      pixCol2_q  <= pixCol1_q;
      vga2_q     <= vga1_q;
      vga3_q     <= out_d;
    end
  end

  // The cursor swaps roles of glyph and background; transparent background shows the input pixel.
  always_comb begin
    glyphBit = char_pixels[3'd7 - pixCol2_q];
    showFg   = glyphBit ^ cursor2_q;
    out_d    = vga2_q;
    if (inWin2_q) begin
      if (showFg)                out_d.rgb = FG;
      else if (TRANSPARENT != 0) out_d.rgb = vga2_q.rgb;
      else                       out_d.rgb = BG;
    end
  end

  assign vga_out.vcount = vga3_q.vcount;
  assign vga_out.vsync  = vga3_q.vsync;
  assign vga_out.vblnk  = vga3_q.vblnk;
  assign vga_out.hcount = vga3_q.hcount;
  assign vga_out.hsync  = vga3_q.hsync;
  assign vga_out.hblnk  = vga3_q.hblnk;
  assign vga_out.rgb    = vga3_q.rgb;

  assign char_code = charCode_q;
  assign char_line = charLine_q;
  assign busy      = busy_q;
  assign wr_ready  = !busy_q;

endmodule

// File: tb/tb_draw_text_box.sv
// tb_draw_text_box: directed vectors plus hand-written clear/cursor sequences for draw_text_box,
// with an opaque 16x16 instance and a small transparent 4x2 instance sharing the video input.
module tb_draw_text_box;

  localparam int          X0     = 48;
  localparam int          Y0     = 64;
  localparam int          COLS   = 16;
  localparam int          ROWS   = 16;
  localparam int          N      = COLS * ROWS;
  localparam logic [11:0] FG     = 12'hfff;
  localparam logic [11:0] BG     = 12'h45c;
`ifdef TEXT_SCALE2_EN
  localparam int          S      = 2;
`else
  localparam int          S      = 1;
`endif

  typedef struct {
    int          dx;
    int          dy;
    logic [11:0] rgbIn;
    logic [2:0]  flags;
    logic [11:0] rgbExp;
    string       name;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  charCode, charPixels, charCodeT, charPixelsT;
  logic [3:0]  charLine, charLineT;
  logic        wrEn, wrReady, clr, busy, cursorEn;
  logic [7:0]  wrAddr, wrData, cursorAddr;
  logic        wrEnT, wrReadyT, clrT, busyT, cursorEnT;
  logic [2:0]  wrAddrT, cursorAddrT;

  int checks;
  int errors;

  vga_if vgaIn();
  vga_if vgaOut();
  vga_if vgaOutT();

  always #5 clk = ~clk;

  draw_text_box #(.BLINK_FRAMES(2)) dut (
    .clk(clk), .rst(rst), .vga_in(vgaIn), .vga_out(vgaOut),
    .char_code(charCode), .char_line(charLine), .char_pixels(charPixels),
    .wr_en(wrEn), .wr_addr(wrAddr), .wr_data(wrData), .wr_ready(wrReady),
    .clr(clr), .busy(busy), .cursor_en(cursorEn), .cursor_addr(cursorAddr)
  );

  draw_text_box #(.COLS(4), .ROWS(2), .TRANSPARENT(1), .BLINK_FRAMES(2)) dutT (
    .clk(clk), .rst(rst), .vga_in(vgaIn), .vga_out(vgaOutT),
    .char_code(charCodeT), .char_line(charLineT), .char_pixels(charPixelsT),
    .wr_en(wrEnT), .wr_addr(wrAddrT), .wr_data(wrData), .wr_ready(wrReadyT),
    .clr(clrT), .busy(busyT), .cursor_en(cursorEnT), .cursor_addr(cursorAddrT)
  );

  // Font ROM model: 'A' is F0 on the upper half of the glyph and 0F on the lower half.
  function automatic logic [7:0] fontRow(input logic [7:0] code, input logic [3:0] line);
    if (code == 8'h41)      return line[3] ? 8'h0F : 8'hF0;
    else if (code == 8'h20) return 8'h00;
    else                    return 8'h81;
  endfunction

  always @(posedge clk) begin
    charPixels  <= fontRow(charCode, charLine);
    charPixelsT <= fontRow(charCodeT, charLineT);
  end

  function automatic logic [37:0] outWord();
    return {vgaOut.vcount, vgaOut.vsync, vgaOut.vblnk,
            vgaOut.hcount, vgaOut.hsync, vgaOut.hblnk, vgaOut.rgb};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [37:0] actual, input logic [37:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input int h, input int v, input logic [11:0] rgb, input logic [2:0] flags);
    vgaIn.hcount = 11'(h);
    vgaIn.vcount = 11'(v);
    vgaIn.rgb    = rgb;
    vgaIn.vsync  = 1'b0;
    {vgaIn.vblnk, vgaIn.hsync, vgaIn.hblnk} = flags;
  endtask

  task automatic pixelAt(input int h, input int v, input logic [11:0] rgb,
                         output logic [11:0] rgbMain, output logic [11:0] rgbT);
    applyStimulus(h, v, rgb, 3'b000);
    repeat (3) tick();
    rgbMain = vgaOut.rgb;
    rgbT    = vgaOutT.rgb;
  endtask

  task automatic readCell(input int a, output logic [7:0] code);
    applyStimulus(X0 + (a % COLS) * 8 * S, Y0 + (a / COLS) * 16 * S, 12'h000, 3'b000);
    tick();
    code = charCode;
  endtask

  task automatic sweepCells(output int bad);
    logic [7:0] code;
    bad = 0;
    for (int a = 0; a < N; a++) begin
      readCell(a, code);
      if (code !== 8'h20) bad++;
    end
  endtask

  task automatic countBusy(output int cycles, output int readyErr);
    cycles   = 0;
    readyErr = 0;
    while (busy === 1'b1 && cycles < 2000) begin
      if (wrReady !== !busy) readyErr++;
      cycles++;
      tick();
    end
    if (wrReady !== !busy) readyErr++;
  endtask

  task automatic writeCell(input int addr, input logic [7:0] data, input bit toT);
    wrData = data;
    if (toT) begin
      wrAddrT = 3'(addr);
      wrEnT   = 1'b1;
    end else begin
      wrAddr = 8'(addr);
      wrEn   = 1'b1;
    end
    tick();
    wrEn  = 1'b0;
    wrEnT = 1'b0;
  endtask

  task automatic pulseVsync();
    vgaIn.vsync = 1'b1;
    tick();
    vgaIn.vsync = 1'b0;
    tick();
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not reach the end, errors so far %0d", errors);
    $fatal(1, "[TB] timeout");
  end

  initial begin
    vec_t        vecs[13];
    logic [37:0] expWord[13];
    logic [11:0] rm, rt;
    logic [7:0]  code;
    int          cyc, rerr, bad, h, v;

    checks = 0;
    errors = 0;
    vecs[0]  = '{8,            16,           12'h0a1, 3'b001, FG,      "c17_px0"};
    vecs[1]  = '{11,           16,           12'h0a2, 3'b010, FG,      "c17_px3"};
    vecs[2]  = '{12,           16,           12'h0a3, 3'b100, BG,      "c17_px4"};
    vecs[3]  = '{15,           16,           12'h0a4, 3'b011, BG,      "c17_px7"};
    vecs[4]  = '{8,            31,           12'h0a5, 3'b000, BG,      "c17_line15_px0"};
    vecs[5]  = '{15,           31,           12'h0a6, 3'b111, FG,      "c17_line15_px7"};
    vecs[6]  = '{-1,           16,           12'h123, 3'b101, 12'h123, "left_edge_outside"};
    vecs[7]  = '{COLS * 8,     16,           12'h456, 3'b000, 12'h456, "right_edge_outside"};
    vecs[8]  = '{8,            ROWS * 16,    12'h789, 3'b110, 12'h789, "bottom_edge_outside"};
    vecs[9]  = '{0,            0,            12'h0b1, 3'b000, BG,      "cell0_first_pixel"};
    vecs[10] = '{COLS * 8 - 1, ROWS * 16 - 1, 12'h0b2, 3'b000, BG,     "cell255_last_pixel"};
    vecs[11] = '{8,            15,           12'h0b3, 3'b000, BG,      "cell1_above_c17"};
    vecs[12] = '{16,           16,           12'h0b4, 3'b000, BG,      "cell18_right_of_c17"};
    for (int i = 0; i < 13; i++) begin
      h = X0 + vecs[i].dx * S;
      v = Y0 + vecs[i].dy * S;
      expWord[i] = {11'(v), 1'b0, vecs[i].flags[2], 11'(h), vecs[i].flags[1], vecs[i].flags[0], vecs[i].rgbExp};
    end

    rst = 1'b1;
    wrEn = 1'b0; wrAddr = '0; wrData = '0; clr = 1'b0; cursorEn = 1'b0; cursorAddr = '0;
    wrEnT = 1'b0; wrAddrT = '0; clrT = 1'b0; cursorEnT = 1'b0; cursorAddrT = '0;
    applyStimulus(300, 200, 12'habc, 3'b111);
    vgaIn.vsync = 1'b1;
    repeat (3) tick();
    checkOutput("reset_vga_out", outWord(), 38'd0);
    checkOutput("reset_char_code", 38'(charCode), 38'd0);
    checkOutput("reset_char_line", 38'(charLine), 38'd0);
    checkOutput("reset_busy_ready", 38'({busy, wrReady}), 38'b10);
    vgaIn.vsync = 1'b0;
    tick();
    rst = 1'b0;

    $display("[TB] clear after reset");
    countBusy(cyc, rerr);
    checkOutput("busy_cycles_after_reset", 38'(cyc), 38'(N));
    checkOutput("wr_ready_is_not_busy", 38'(rerr), 38'd0);
    sweepCells(bad);
    checkOutput("cells_space_after_reset", 38'(bad), 38'd0);

    writeCell(17, 8'h41, 1'b0);
    readCell(17, code);
    checkOutput("write_visible_next_clk", 38'(code), 38'h41);
    writeCell(1, 8'h41, 1'b1);

    $display("[TB] vector stream");
    for (int k = 0; k < 16; k++) begin
      if (k >= 3) checkOutput(vecs[k - 3].name, outWord(), expWord[k - 3]);
      if (k < 13) applyStimulus(X0 + vecs[k].dx * S, Y0 + vecs[k].dy * S, vecs[k].rgbIn, vecs[k].flags);
      tick();
    end

    $display("[TB] transparent instance");
    pixelAt(X0 + 8 * S, Y0, 12'h123, rm, rt);
    checkOutput("transp_glyph_fg", 38'(rt), 38'(FG));
    checkOutput("opaque_space_bg", 38'(rm), 38'(BG));
    pixelAt(X0 + 8 * S + S - 1, Y0 + S - 1, 12'h123, rm, rt);
    checkOutput("transp_glyph_fg_scaled_corner", 38'(rt), 38'(FG));
    pixelAt(X0 + 12 * S, Y0, 12'h123, rm, rt);
    checkOutput("transp_glyph_bg_passthrough", 38'(rt), 38'h123);
    pixelAt(X0 + 12 * S + S - 1, Y0 + S - 1, 12'h123, rm, rt);
    checkOutput("transp_bg_scaled_corner", 38'(rt), 38'h123);
    pixelAt(X0, Y0, 12'h3c3, rm, rt);
    checkOutput("transp_space_passthrough", 38'(rt), 38'h3c3);

    $display("[TB] cursor blink");
    cursorEn   = 1'b1;
    cursorAddr = 8'd0;
    for (int f = 0; f < 6; f++) begin
      if (f > 0) pulseVsync();
      pixelAt(X0, Y0, 12'h0f0, rm, rt);
      checkOutput($sformatf("cursor_frame%0d", f), 38'(rm), 38'((f == 2 || f == 3) ? FG : BG));
      if (f == 3) begin
        pixelAt(X0 + 8 * S, Y0, 12'h0f0, rm, rt);
        checkOutput("cursor_other_cell_normal", 38'(rm), 38'(BG));
        cursorEn = 1'b0;
        pixelAt(X0, Y0, 12'h0f0, rm, rt);
        checkOutput("cursor_disabled_normal", 38'(rm), 38'(BG));
        cursorEn = 1'b1;
      end
    end
    cursorEn = 1'b0;

    $display("[TB] clear with dropped write and repeated clr");
    clr = 1'b1;
    tick();
    clr = 1'b0;
    cyc = 0;
    while (busy === 1'b1 && cyc < 2000) begin
      if (cyc == 5) begin
        wrAddr = 8'd2;
        wrData = 8'h55;
        wrEn   = 1'b1;
      end else begin
        wrEn = 1'b0;
      end
      clr = (cyc == 50);
      cyc++;
      tick();
    end
    wrEn = 1'b0;
    clr  = 1'b0;
    checkOutput("clear_busy_cycles", 38'(cyc), 38'(N));
    readCell(2, code);
    checkOutput("write_while_busy_dropped", 38'(code), 38'h20);
    readCell(17, code);
    checkOutput("cell17_cleared", 38'(code), 38'h20);
    sweepCells(bad);
    checkOutput("cells_space_after_clr", 38'(bad), 38'd0);

    $display("[TB] reset during clear");
    clr = 1'b1;
    tick();
    clr = 1'b0;
    cyc = 0;
    while (busy === 1'b1 && cyc < 100) begin
      cyc++;
      tick();
    end
    rst = 1'b1;
    tick();
    checkOutput("busy_during_reset_mid_clear", 38'(busy), 38'd1);
    rst = 1'b0;
    countBusy(cyc, rerr);
    checkOutput("busy_cycles_after_mid_reset", 38'(cyc), 38'(N));
    checkOutput("wr_ready_after_mid_reset", 38'(rerr), 38'd0);
    sweepCells(bad);
    checkOutput("cells_space_after_mid_reset", 38'(bad), 38'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
